// File: rtl/dcache_ctrl.sv
// dcache_ctrl: sequencing FSM for the 2-way set-associative data cache.
// Handles miss (writeback + two-word line fill), snoop response with
// preemption of not-yet-granted bus requests, and the halt-time flush.
// Ports:
//   CLK, nRST           clock, synchronous active-low reset
//   dmemREN/WEN/addr    datapath request; halt starts the flush
//   hit, lru, vic_*     access-logic decisions for the indexed set / victim
//   snp_dirty           snooped line present and dirty
//   dwait, dload        bus handshake (dload is written by the array itself)
//   ccwait/ccinv/addr   coherence snoop request from the bus controller
//   dREN/dWEN/daddr/dstore, cctrans/ccwrite   bus side
//   snoop               access logic decodes ccsnoopaddr
//   fill_en/way/word    array fill strobe; flush_idx {way,set}; flushed sticky
module dcache_ctrl #(
  parameter int SETS = 8
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    dmemREN,
  input  logic                    dmemWEN,
  input  logic [31:0]             dmemaddr,
  input  logic                    halt,
  input  logic                    hit,
  input  logic                    lru,
  input  logic                    vic_valid,
  input  logic                    vic_dirty,
  input  logic [31-$clog2(SETS)-3+1-1:0] vic_tag,
  input  logic [63:0]             vic_data,
  input  logic                    snp_dirty,
  input  logic                    dwait,
  input  logic [31:0]             dload,
  input  logic                    ccwait,
  input  logic                    ccinv,
  input  logic [31:0]             ccsnoopaddr,
  output logic                    dREN,
  output logic                    dWEN,
  output logic [31:0]             daddr,
  output logic [31:0]             dstore,
  output logic                    cctrans,
  output logic                    ccwrite,
  output logic                    snoop,
  output logic                    fill_en,
  output logic                    fill_way,
  output logic                    fill_word,
  output logic [$clog2(SETS):0]   flush_idx,
  output logic                    flushed
);
  localparam int IW = $clog2(SETS);

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, LD0, LD1, SNP, SWB0, SWB1, FLUSH, FWB0, FWB1, HALTED
  } state_t;

  state_t state;
  state_t ret;   // where to go once a snoop has been serviced

  logic          miss_req, vic_wb, preempt, last_idx, wrd;
  logic [IW-1:0] set_sel;

  // dload is consumed by the array; invalidation is handled by access logic.
  logic unused;
  assign unused = ^{dload, ccinv, dmemaddr[2:0]};

  assign miss_req = (dmemREN | dmemWEN) & ~hit;
  assign vic_wb   = vic_valid & vic_dirty;
  assign last_idx = &flush_idx;
  // A first-word request still waiting for grant yields to an incoming snoop.
  assign preempt  = ((state == WB0) || (state == LD0)) && ccwait && dwait;
  assign wrd      = (state == WB1) || (state == LD1) || (state == SWB1) || (state == FWB1);
  assign set_sel  = ((state == FWB0) || (state == FWB1)) ? flush_idx[IW-1:0]
                                                         : dmemaddr[IW+2:3];

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      ret       <= IDLE;
      flush_idx <= '0;
      flushed   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ccwait) begin
            state <= SNP;
            ret   <= IDLE;
          end else if (halt)   state <= FLUSH;
          else if (miss_req)   state <= vic_wb ? WB0 : LD0;
        end
        WB0: begin
          if (preempt) begin
            state <= SNP;
            ret   <= WB0;
          end else if (!dwait) state <= WB1;
        end
        WB1: if (!dwait) state <= LD0;
        LD0: begin
          if (preempt) begin
            state <= SNP;
            ret   <= LD0;
          end else if (!dwait) state <= LD1;
        end
        LD1: if (!dwait) state <= IDLE;
        SNP: begin
          if (snp_dirty) state <= SWB0;
          else if (!ccwait) begin
            state <= ret;
            ret   <= IDLE;
          end
        end
        SWB0: if (!dwait) state <= SWB1;
        SWB1: begin
          if (!dwait) begin
            state <= ret;
            ret   <= IDLE;
          end
        end
        FLUSH: begin
          if (ccwait) begin
            state <= SNP;
            ret   <= FLUSH;
          end else if (vic_wb) state <= FWB0;
          else if (last_idx) begin
            state   <= HALTED;
            flushed <= 1'b1;
          end else flush_idx <= flush_idx + 1'b1;
        end
        FWB0: if (!dwait) state <= FWB1;
        FWB1: begin
          if (!dwait) begin
            if (last_idx) begin
              state   <= HALTED;
              flushed <= 1'b1;
            end else begin
              state     <= FLUSH;
              flush_idx <= flush_idx + 1'b1;
            end
          end
        end
        HALTED: begin
          if (ccwait) begin
            state <= SNP;
            ret   <= HALTED;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    dREN      = 1'b0;
    dWEN      = 1'b0;
    daddr     = '0;
    dstore    = '0;
    cctrans   = 1'b0;
    ccwrite   = 1'b0;
    snoop     = 1'b0;
    fill_en   = 1'b0;
    fill_way  = 1'b0;
    fill_word = 1'b0;
    case (state)
      WB0, WB1, FWB0, FWB1: begin
        dWEN   = ~preempt;
        daddr  = {vic_tag, set_sel, wrd, 2'b00};
        dstore = wrd ? vic_data[63:32] : vic_data[31:0];
      end
      LD0, LD1: begin
        dREN      = ~preempt;
        cctrans   = ~preempt;
        ccwrite   = dmemWEN & ~preempt;
        daddr     = {dmemaddr[31:3], wrd, 2'b00};
        // nRST gate: a word landing while reset is held is never committed.
        fill_en   = nRST & ~dwait;
        fill_way  = lru;
        fill_word = wrd;
      end
      SNP: begin
        snoop   = 1'b1;
        cctrans = 1'b1;
        ccwrite = snp_dirty;
      end
      SWB0, SWB1: begin
        snoop   = 1'b1;
        ccwrite = 1'b1;
        daddr   = {ccsnoopaddr[31:3], wrd, 2'b00};
        dstore  = wrd ? vic_data[63:32] : vic_data[31:0];
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;
  localparam int SETS = 8;
  localparam int IW   = 3;
  localparam int TW   = 26;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        cw;
  } bw_t;

  logic          CLK, nRST, dmemREN, dmemWEN, halt, hit, lru, vic_valid, vic_dirty;
  logic          snp_dirty, dwait, ccwait, ccinv;
  logic [31:0]   dmemaddr, dload, ccsnoopaddr;
  logic [TW-1:0] vic_tag;
  logic [63:0]   vic_data;
  logic          dREN, dWEN, cctrans, ccwrite, snoop, fill_en, fill_way, fill_word, flushed;
  logic [31:0]   daddr, dstore;
  logic [IW:0]   flush_idx;

  int compared = 0, mismatched = 0;

  dcache_ctrl #(.SETS(SETS)) dut (
    .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .halt(halt), .hit(hit), .lru(lru), .vic_valid(vic_valid), .vic_dirty(vic_dirty),
    .vic_tag(vic_tag), .vic_data(vic_data), .snp_dirty(snp_dirty), .dwait(dwait),
    .dload(dload), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .cctrans(cctrans),
    .ccwrite(ccwrite), .snoop(snoop), .fill_en(fill_en), .fill_way(fill_way),
    .fill_word(fill_word), .flush_idx(flush_idx), .flushed(flushed)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    dmemREN = 0; dmemWEN = 0; dmemaddr = '0; halt = 0; hit = 0; lru = 0;
    vic_valid = 0; vic_dirty = 0; vic_tag = '0; vic_data = '0; snp_dirty = 0;
    dwait = 0; ccwait = 0; ccinv = 0; ccsnoopaddr = '0; dload = $urandom;
  endtask

  task automatic test_reset();
    nRST = 0; ccwait = 1; halt = 1; dmemREN = 1; hit = 0; dwait = 0;
    vic_valid = 1; vic_dirty = 1; snp_dirty = 1;
    step(); step();
    @(negedge CLK);
    compared++;
    if ({dREN, dWEN, cctrans, ccwrite, snoop, fill_en, fill_way, fill_word, flushed} !== 9'b0 ||
        daddr !== 32'h0 || dstore !== 32'h0 || flush_idx !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got ctl=%b daddr=%h dstore=%h fidx=%0d, want all zero",
               {dREN, dWEN, cctrans, ccwrite, snoop, fill_en, fill_way, fill_word, flushed},
               daddr, dstore, flush_idx);
    end
    step();
    idle_in(); nRST = 1;
    step();
  endtask

  // Each miss: model the expected bus word list (writeback words then fill words).
  task automatic test_misses();
    for (int n = 0; n < 24; n++) begin
      logic [31:0] a;
      logic wen, l, vv, vd;
      logic [TW-1:0] vt;
      logic [63:0] vdat;
      int mode, act, cyc, hc, words, per;
      bw_t q[$];
      bw_t e;
      logic efe;
      if (n == 0) begin
        a = 32'h0000_0040; wen = 0; l = 1'($urandom); vv = 1; vd = 0; mode = 0;
      end else if (n == 1) begin
        a = 32'h0000_0820; wen = 1; l = 1'($urandom); vv = 1; vd = 1; mode = 1;
      end else begin
        a = $urandom; wen = 1'($urandom); l = 1'($urandom); vv = 1'($urandom);
        vd = 1'($urandom); mode = $urandom_range(0, 2);
      end
      vt = (n == 1) ? TW'(1) : TW'($urandom);
      vdat = {$urandom, $urandom};
      if (vv && vd) begin
        e.wr = 1; e.cw = 0;
        e.addr = {vt, a[IW+2:3], 1'b0, 2'b00}; e.data = vdat[31:0];  q.push_back(e);
        e.addr = {vt, a[IW+2:3], 1'b1, 2'b00}; e.data = vdat[63:32]; q.push_back(e);
      end
      e.wr = 0; e.cw = wen; e.data = '0;
      e.addr = {a[31:3], 1'b0, 2'b00}; q.push_back(e);
      e.addr = {a[31:3], 1'b1, 2'b00}; q.push_back(e);
      words = q.size();
      per = (mode == 1) ? 3 : 1;

      dmemREN = ~wen; dmemWEN = wen; dmemaddr = a; hit = 0; lru = l;
      vic_valid = vv; vic_dirty = vd; vic_tag = vt; vic_data = vdat; dwait = 1;
      @(negedge CLK);
      compared++;
      if (dREN !== 1'b0 || dWEN !== 1'b0) begin
        mismatched++;
        $display("FAIL miss_detect[%0d]: got dREN=%b dWEN=%b, want 0 0", n, dREN, dWEN);
      end
      step();

      act = 0; cyc = 0; hc = 0;
      while (q.size() > 0 && cyc < 100) begin
        case (mode)
          0: dwait = 0;
          1: dwait = (hc < 2);
          default: dwait = 1'($urandom);
        endcase
        @(negedge CLK);
        compared++;
        if ((dREN && dWEN) || snoop) begin
          mismatched++;
          $display("FAIL miss_excl[%0d]: got dREN=%b dWEN=%b snoop=%b", n, dREN, dWEN, snoop);
        end
        if (dREN || dWEN) begin
          act++;
          compared++;
          if (dWEN !== q[0].wr || daddr !== q[0].addr || (q[0].wr && dstore !== q[0].data) ||
              (!q[0].wr && (ccwrite !== q[0].cw || cctrans !== 1'b1))) begin
            mismatched++;
            $display("FAIL miss_word[%0d]: got wen=%b addr=%h data=%h ccw=%b, want wen=%b addr=%h data=%h ccw=%b",
                     n, dWEN, daddr, dstore, ccwrite, q[0].wr, q[0].addr, q[0].data, q[0].cw);
          end
          efe = !q[0].wr && !dwait;
          compared++;
          if (fill_en !== efe || (efe && (fill_way !== l || fill_word !== q[0].addr[2]))) begin
            mismatched++;
            $display("FAIL miss_fill[%0d]: got en=%b way=%b word=%b, want en=%b way=%b word=%b",
                     n, fill_en, fill_way, fill_word, efe, l, q[0].addr[2]);
          end
          if (!dwait) begin
            void'(q.pop_front());
            hc = 0;
          end else hc++;
        end
        step();
        cyc++;
      end
      compared++;
      if (q.size() != 0) begin
        mismatched++;
        $display("FAIL miss_timeout[%0d]: got %0d words left, want 0", n, q.size());
      end
      if (mode != 2) begin
        compared++;
        if (act != words * per) begin
          mismatched++;
          $display("FAIL miss_latency[%0d]: got %0d bus cycles, want %0d", n, act, words * per);
        end
      end
      hit = 1; dwait = 1'($urandom);
      @(negedge CLK);
      compared++;
      if (dREN !== 1'b0 || dWEN !== 1'b0 || fill_en !== 1'b0) begin
        mismatched++;
        $display("FAIL miss_hit_idle[%0d]: got dREN=%b dWEN=%b fill=%b, want 0", n, dREN, dWEN, fill_en);
      end
      step();
      idle_in();
    end
  endtask

  task automatic test_snoop_ld0();
    logic [31:0] a, s;
    logic [63:0] d;
    a = {$urandom_range(0, 32'h1FFF_FFFF), 3'b000}; s = $urandom; d = {$urandom, $urandom};
    dmemREN = 1; dmemaddr = a; hit = 0; vic_valid = 0; lru = 1; dwait = 1;
    @(negedge CLK); step();                               // detect
    @(negedge CLK);
    compared++;
    if (dREN !== 1 || daddr !== a) begin
      mismatched++; $display("FAIL snp_ld0_req: got dREN=%b addr=%h, want 1 %h", dREN, daddr, a);
    end
    step();
    ccwait = 1; ccsnoopaddr = s;
    @(negedge CLK);
    compared++;
    if (dREN !== 0 || dWEN !== 0 || snoop !== 0) begin
      mismatched++; $display("FAIL snp_preempt: got dREN=%b dWEN=%b snoop=%b, want 0 0 0", dREN, dWEN, snoop);
    end
    step();
    snp_dirty = 1; vic_data = d;
    @(negedge CLK);
    compared++;
    if (snoop !== 1 || cctrans !== 1 || ccwrite !== 1 || dREN !== 0) begin
      mismatched++; $display("FAIL snp_state: got snoop=%b cctrans=%b ccwrite=%b dREN=%b, want 1 1 1 0",
                             snoop, cctrans, ccwrite, dREN);
    end
    step();
    dwait = 0;
    for (int w = 0; w < 2; w++) begin
      @(negedge CLK);
      compared++;
      if (snoop !== 1 || ccwrite !== 1 || dREN !== 0 || dWEN !== 0 ||
          daddr !== {s[31:3], 3'(w * 4)} || dstore !== (w == 0 ? d[31:0] : d[63:32])) begin
        mismatched++;
        $display("FAIL snp_wb%0d: got snoop=%b ccw=%b addr=%h data=%h, want 1 1 %h %h", w, snoop,
                 ccwrite, daddr, dstore, {s[31:3], 3'(w * 4)}, (w == 0 ? d[31:0] : d[63:32]));
      end
      step();
    end
    ccwait = 0; snp_dirty = 0;
    for (int w = 0; w < 2; w++) begin
      @(negedge CLK);
      compared++;
      if (snoop !== 0 || dREN !== 1 || daddr !== (a + 32'(w * 4)) || fill_en !== 1 ||
          fill_word !== 1'(w) || fill_way !== 1) begin
        mismatched++;
        $display("FAIL snp_resume_ld%0d: got snoop=%b dREN=%b addr=%h fill=%b word=%b, want 0 1 %h 1 %0d",
                 w, snoop, dREN, daddr, fill_en, fill_word, a + 32'(w * 4), w);
      end
      step();
    end
    hit = 1;
    @(negedge CLK);
    compared++;
    if (dREN !== 0) begin
      mismatched++; $display("FAIL snp_done_idle: got dREN=%b, want 0", dREN);
    end
    step();
    idle_in();
  endtask

  task automatic test_snoop_clean();
    int k;
    logic [31:0] a, wa;
    logic [TW-1:0] vt;
    k = $urandom_range(2, 4);
    ccwait = 1;
    for (int c = 0; c <= k + 1; c++) begin
      if (c == k) ccwait = 0;
      @(negedge CLK);
      compared++;
      if (snoop !== (c >= 1 && c <= k) || ccwrite !== 0 || dREN !== 0 || dWEN !== 0 ||
          cctrans !== (c >= 1 && c <= k)) begin
        mismatched++;
        $display("FAIL snp_clean[%0d]: got snoop=%b cctrans=%b ccw=%b, want %b %b 0", c, snoop, cctrans,
                 ccwrite, (c >= 1 && c <= k), (c >= 1 && c <= k));
      end
      step();
    end
    // preempt a writeback that has not been granted, then resume it
    a = $urandom; vt = TW'($urandom); wa = {vt, a[IW+2:3], 3'b000};
    dmemREN = 1; dmemaddr = a; vic_valid = 1; vic_dirty = 1; vic_tag = vt;
    vic_data = {$urandom, $urandom}; dwait = 1;
    @(negedge CLK); step();
    ccwait = 1;
    @(negedge CLK);
    compared++;
    if (dWEN !== 0) begin
      mismatched++; $display("FAIL snp_wb0_preempt: got dWEN=%b, want 0", dWEN);
    end
    step();
    ccwait = 0;
    @(negedge CLK); step();                               // SNP, clean, releases
    dwait = 0;
    @(negedge CLK);
    compared++;
    if (dWEN !== 1 || daddr !== wa || dstore !== vic_data[31:0]) begin
      mismatched++; $display("FAIL snp_wb0_resume: got dWEN=%b addr=%h data=%h, want 1 %h %h",
                             dWEN, daddr, dstore, wa, vic_data[31:0]);
    end
    step();
    nRST = 0; idle_in(); step(); nRST = 1; step();
  endtask

  task automatic test_flush(input bit rnd);
    logic av[16], ad[16];
    logic [TW-1:0] at[16];
    logic [63:0] adat[16];
    logic [3:0] ii;
    bw_t q[$];
    bw_t e;
    int nd, cyc;
    nRST = 0; idle_in(); step(); nRST = 1;
    nd = 0;
    for (int i = 0; i < 16; i++) begin
      ii = 4'(i);
      av[i] = rnd ? 1'($urandom) : 1'($urandom);
      ad[i] = rnd ? 1'($urandom) : (i == 7 || i == 11);
      if (!rnd && ad[i]) av[i] = 1;
      at[i] = TW'($urandom); adat[i] = {$urandom, $urandom};
      if (av[i] && ad[i]) begin
        nd++;
        e.wr = 1; e.cw = 0;
        e.addr = {at[i], ii[IW-1:0], 3'b000}; e.data = adat[i][31:0];  q.push_back(e);
        e.addr = {at[i], ii[IW-1:0], 3'b100}; e.data = adat[i][63:32]; q.push_back(e);
      end
    end
    halt = 1;
    @(negedge CLK);
    compared++;
    if (dWEN !== 0 || flushed !== 0) begin
      mismatched++; $display("FAIL flush_start: got dWEN=%b flushed=%b, want 0 0", dWEN, flushed);
    end
    step();
    cyc = 0;
    while (cyc < 300) begin
      vic_valid = av[flush_idx]; vic_dirty = ad[flush_idx];
      vic_tag = at[flush_idx]; vic_data = adat[flush_idx];
      dwait = rnd ? 1'($urandom) : 1'b0;
      @(negedge CLK);
      if (flushed) break;
      compared++;
      if (dREN !== 0 || snoop !== 0 || (dWEN && (q.size() == 0 || daddr !== q[0].addr || dstore !== q[0].data))) begin
        mismatched++;
        $display("FAIL flush_word: got dREN=%b dWEN=%b addr=%h data=%h, want write %h %h", dREN, dWEN,
                 daddr, dstore, (q.size() > 0) ? q[0].addr : 32'h0, (q.size() > 0) ? q[0].data : 32'h0);
      end
      if (dWEN && !dwait && q.size() > 0) void'(q.pop_front());
      cyc++;
      step();
    end
    compared++;
    if (flushed !== 1 || q.size() != 0) begin
      mismatched++; $display("FAIL flush_done: got flushed=%b words_left=%0d, want 1 0", flushed, q.size());
    end
    if (!rnd) begin
      compared++;
      if (cyc != 16 + 2 * nd) begin
        mismatched++; $display("FAIL flush_cycles: got %0d, want %0d", cyc, 16 + 2 * nd);
      end
    end
    step();
  endtask

  task automatic test_halted_snoop();
    ccwait = 1; snp_dirty = 0; vic_valid = 0; vic_dirty = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) ccwait = 0;
      @(negedge CLK);
      compared++;
      if (flushed !== 1 || snoop !== (c == 1 || c == 2) || dREN !== 0 || dWEN !== 0) begin
        mismatched++;
        $display("FAIL halted_snoop[%0d]: got flushed=%b snoop=%b, want 1 %b", c, flushed, snoop, (c == 1 || c == 2));
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    nRST = 0; idle_in(); step();
    @(negedge CLK);
    compared++;
    if (flushed !== 0 || flush_idx !== '0) begin
      mismatched++; $display("FAIL reset_flushed: got flushed=%b fidx=%0d, want 0 0", flushed, flush_idx);
    end
    step();
    nRST = 1;
    a = $urandom;
    dmemREN = 1; dmemaddr = a; vic_valid = 1; vic_dirty = 1; vic_tag = TW'($urandom);
    vic_data = {$urandom, $urandom}; dwait = 1;
    @(negedge CLK); step();
    dwait = 0;
    @(negedge CLK);
    compared++;
    if (dWEN !== 1 || daddr !== {vic_tag, a[IW+2:3], 3'b000}) begin
      mismatched++; $display("FAIL reset_mid_wb0: got dWEN=%b addr=%h, want 1 %h", dWEN, daddr,
                             {vic_tag, a[IW+2:3], 3'b000});
    end
    step();
    dwait = 1; nRST = 0;
    @(negedge CLK); step();
    nRST = 1; dwait = 0;
    @(negedge CLK);
    compared++;
    if (dWEN !== 0 || dREN !== 0 || fill_en !== 0 || flushed !== 0) begin
      mismatched++; $display("FAIL reset_mid: got dWEN=%b dREN=%b fill=%b flushed=%b, want 0 0 0 0",
                             dWEN, dREN, fill_en, flushed);
    end
    step();
    idle_in();
    step();
  endtask

  initial begin
    idle_in();
    test_reset();
    test_misses();
    test_snoop_ld0();
    test_snoop_clean();
    test_flush(1'b0);
    test_halted_snoop();
    test_reset_mid();
    test_flush(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
